// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//
// It turns per-stage stall requests into the stall vector that feeds pc_reg
// and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences an
// exception/ERET in three steps: freeze the pipe, flush it, then redirect
// the PC. It also runs a stall watchdog and counts stalled cycles for debug.
//
// Ports
//   i_clk           clock; all state updates on the rising edge
//   i_rst_n         asynchronous active-low reset
//   i_stallreq_if   fetch bus wait
//   i_stallreq_id   load-use hazard
//   i_stallreq_ex   multi-cycle op (div/madd)
//   i_stallreq_mem  data bus wait
//   i_excp_valid    exception committed in MEM this cycle
//   i_excp_eret     qualifies i_excp_valid as ERET
//   i_cp0_epc       EPC value, sampled together with i_excp_valid
//   o_stall         stall vector (bit0=PC .. bit5=WB), combinational
//   o_flush         one-cycle flush pulse for all pipeline registers
//   o_new_pc        redirect target, valid while o_flush=1
//   o_wdog_err      sticky watchdog error
//   o_stall_cycles  number of cycles with o_stall!=0 (wraps)
module pipe_ctrl #(
  parameter int unsigned       N_STALL    = 6,
  parameter int unsigned       N_REG      = 32,
  parameter logic [N_REG-1:0]  EXC_VECTOR = 32'h0000_0020,
  parameter logic [15:0]       WDOG_MAX   = 16'd1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stallreq_if,
  input  logic               i_stallreq_id,
  input  logic               i_stallreq_ex,
  input  logic               i_stallreq_mem,
  input  logic               i_excp_valid,
  input  logic               i_excp_eret,
  input  logic [N_REG-1:0]   i_cp0_epc,
  output logic [N_STALL-1:0] o_stall,
  output logic               o_flush,
  output logic [N_REG-1:0]   o_new_pc,
  output logic               o_wdog_err,
  output logic [31:0]        o_stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Each pattern stops the requesting stage and everything before it; the
  // stage after the requester receives a bubble.
  localparam logic [N_STALL-1:0] STALL_ALL  = N_STALL'(6'b111111);
  localparam logic [N_STALL-1:0] STALL_MEM  = N_STALL'(6'b011111);
  localparam logic [N_STALL-1:0] STALL_EX   = N_STALL'(6'b001111);
  localparam logic [N_STALL-1:0] STALL_ID   = N_STALL'(6'b000111);
  localparam logic [N_STALL-1:0] STALL_IF   = N_STALL'(6'b000011);
  localparam logic [N_STALL-1:0] STALL_NONE = '0;

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic [N_REG-1:0]   new_pc_q, new_pc_d;
  logic [15:0]        wdog_cnt_q, wdog_cnt_d;
  logic               wdog_err_q, wdog_err_d;
  logic [31:0]        stall_cycles_q, stall_cycles_d;
  logic               stall_any;
  logic               excp_take;

  // An exception is only accepted from IDLE; in HOLD/FLUSH the pipe is
  // already being emptied.
  assign excp_take = (state_q == ST_IDLE) && i_excp_valid;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_excp_valid) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: stall vector is combinational so the pipeline registers
  // see it in the same cycle the request appears.
  always_comb begin
    o_stall = STALL_NONE;
    case (state_q)
      ST_HOLD:  o_stall = STALL_ALL;
      ST_FLUSH: o_stall = STALL_NONE;
      ST_IDLE: begin
        if (i_excp_valid)        o_stall = STALL_ALL;
        else if (i_stallreq_mem) o_stall = STALL_MEM;
        else if (i_stallreq_ex)  o_stall = STALL_EX;
        else if (i_stallreq_id)  o_stall = STALL_ID;
        else if (i_stallreq_if)  o_stall = STALL_IF;
        else                     o_stall = STALL_NONE;
      end
      default:  o_stall = STALL_NONE;
    endcase
  end

  assign stall_any = |o_stall;

  // Redirect, watchdog and debug counter next values
  always_comb begin
    flush_d        = (state_q == ST_HOLD);
    new_pc_d       = new_pc_q;
    if (excp_take) begin
      new_pc_d = i_excp_eret ? i_cp0_epc : EXC_VECTOR;
    end

    wdog_cnt_d = '0;
    if (stall_any) begin
      wdog_cnt_d = (wdog_cnt_q >= WDOG_MAX) ? WDOG_MAX : wdog_cnt_q + 16'd1;
    end
    wdog_err_d     = wdog_err_q | (wdog_cnt_d == WDOG_MAX);

    stall_cycles_d = stall_any ? stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flush_q        <= 1'b0;
      new_pc_q       <= '0;
      wdog_cnt_q     <= '0;
      wdog_err_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      wdog_cnt_q     <= wdog_cnt_d;
      wdog_err_q     <= wdog_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_flush        = flush_q;
  assign o_new_pc       = new_pc_q;
  assign o_wdog_err     = wdog_err_q;
  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam logic [15:0] WD = 16'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic        excp, eret;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_err;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model: exception phase (0 idle, 1 frozen, 2 flushing),
  // captured target, consecutive-stall run length, sticky error, stall count.
  int          m_phase;
  logic [31:0] m_pc;
  int          m_run;
  logic        m_err;
  logic [31:0] m_cyc;

  always #5 clk = ~clk;

  pipe_ctrl #(.WDOG_MAX(WD)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stallreq_if(sr_if), .i_stallreq_id(sr_id),
    .i_stallreq_ex(sr_ex), .i_stallreq_mem(sr_mem),
    .i_excp_valid(excp), .i_excp_eret(eret), .i_cp0_epc(epc),
    .o_stall(stall), .o_flush(flush), .o_new_pc(new_pc),
    .o_wdog_err(wdog_err), .o_stall_cycles(stall_cycles)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected stall: freeze all while an exception is being taken, nothing
  // while flushing, otherwise all stages up to the deepest requester.
  function automatic logic [5:0] exp_stall();
    int d;
    if (m_phase == 1) return 6'h3f;
    if (m_phase == 2) return 6'h00;
    if (excp) return 6'h3f;
    d = sr_mem ? 4 : sr_ex ? 3 : sr_id ? 2 : sr_if ? 1 : 0;
    if (d == 0) return 6'h00;
    return 6'((1 << (d + 1)) - 1);
  endfunction

  task automatic model_clear();
    m_phase = 0; m_pc = 0; m_run = 0; m_err = 0; m_cyc = 0;
  endtask

  task automatic idle_inputs();
    sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0;
    excp = 0; eret = 0; epc = 32'h0;
  endtask

  // Advance one clock edge and move the model forward with the inputs
  // present at that edge; returns 1 ns after the edge.
  task automatic tick();
    logic [5:0]  s;
    int          nph;
    logic [31:0] npc;
    s   = exp_stall();
    nph = m_phase;
    npc = m_pc;
    if (m_phase == 0 && excp) begin
      nph = 1;
      npc = eret ? epc : 32'h0000_0020;
    end else if (m_phase == 1) nph = 2;
    else if (m_phase == 2)     nph = 0;
    @(posedge clk);
    m_phase = nph;
    m_pc    = npc;
    if (s != 0) begin
      m_run = (m_run < int'(WD)) ? m_run + 1 : int'(WD);
      m_cyc = m_cyc + 1;
    end else begin
      m_run = 0;
    end
    if (m_run == int'(WD)) m_err = 1;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    model_clear();
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_clear();
    #3;
    checks++; if (stall !== 6'h00) begin errors++; $display("FAIL reset_stall got=%h exp=00", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog got=%b exp=0", wdog_err); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", stall_cycles); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_priority();
    reset_dut();
    sr_if = 1; sr_id = 1; sr_mem = 1;
    #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem got=%b exp=011111", stall); end
    tick();
    sr_mem = 0;
    #1;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL prio_id got=%b exp=000111", stall); end
    sr_id = 0;
    #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if got=%b exp=000011", stall); end
    sr_if = 0; sr_ex = 1;
    #1;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL prio_ex got=%b exp=001111", stall); end
    sr_ex = 0;
    #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_none got=%b exp=000000", stall); end
    tick();
    checks++; if (stall_cycles !== m_cyc) begin errors++; $display("FAIL prio_cycles got=%0d exp=%0d", stall_cycles, m_cyc); end
  endtask

  task automatic test_exception();
    reset_dut();
    excp = 1; eret = 0; epc = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL exc_stall_n got=%b exp=111111", stall); end
    tick();
    excp = 0;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL exc_stall_n1 got=%b exp=111111", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_n1 got=%b exp=0", flush); end
    tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush_n2 got=%b exp=1", flush); end
    checks++; if (new_pc !== 32'h0000_0020) begin errors++; $display("FAIL exc_new_pc got=%h exp=00000020", new_pc); end
    checks++; if (stall !== 6'h00) begin errors++; $display("FAIL exc_stall_n2 got=%b exp=000000", stall); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_n3 got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0000_0020) begin errors++; $display("FAIL exc_pc_hold got=%h exp=00000020", new_pc); end
  endtask

  task automatic test_eret();
    int pulses;
    reset_dut();
    pulses = 0;
    excp = 1; eret = 1; epc = 32'hBFC0_0100;
    tick();
    epc = 32'h1234_5678;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL eret_hold_stall got=%b exp=111111", stall); end
    tick();
    excp = 0; eret = 0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got=%b exp=1", flush); end
    checks++; if (new_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL eret_new_pc got=%h exp=bfc00100", new_pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flush === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL eret_single_pulse extra=%0d exp=0", pulses); end
    checks++; if (new_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL eret_pc_hold got=%h exp=bfc00100", new_pc); end
  endtask

  task automatic test_excp_during_stall();
    reset_dut();
    sr_ex = 1; excp = 1;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL exst_idle got=%b exp=111111", stall); end
    tick();
    excp = 0;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL exst_hold got=%b exp=111111", stall); end
    tick();
    checks++; if (stall !== 6'h00) begin errors++; $display("FAIL exst_flush got=%b exp=000000", stall); end
    tick();
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL exst_back got=%b exp=001111", stall); end
    sr_ex = 0;
    tick();
  endtask

  task automatic test_watchdog();
    reset_dut();
    sr_mem = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) begin
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early got=%b exp=0", wdog_err); end
      end
    end
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_set got=%b exp=1", wdog_err); end
    sr_mem = 0;
    tick();
    tick();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
    checks++; if (stall_cycles !== 32'd8) begin errors++; $display("FAIL wdog_cycles got=%0d exp=8", stall_cycles); end
  endtask

  task automatic test_reset_in_hold();
    int pulses;
    reset_dut();
    pulses = 0;
    excp = 1; eret = 1; epc = 32'hCAFE_0000;
    tick();
    excp = 0; eret = 0;
    #1;
    checks++; if (stall !== 6'h3f) begin errors++; $display("FAIL rsth_hold got=%b exp=111111", stall); end
    rst_n = 0;
    #1;
    model_clear();
    checks++; if (stall !== 6'h00) begin errors++; $display("FAIL rsth_stall got=%b exp=000000", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rsth_flush got=%b exp=0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL rsth_new_pc got=%h exp=0", new_pc); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL rsth_cycles got=%0d exp=0", stall_cycles); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flush === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rsth_no_flush pulses=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    logic [5:0] es;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      sr_if  = ($urandom_range(0, 3) == 0);
      sr_id  = ($urandom_range(0, 3) == 0);
      sr_ex  = ($urandom_range(0, 3) == 0);
      sr_mem = ($urandom_range(0, 2) != 0);
      excp   = ($urandom_range(0, 9) == 0);
      eret   = $urandom_range(0, 1) == 1;
      epc    = $urandom;
      #1;
      es = exp_stall();
      checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, es); end
      checks++; if (flush !== (m_phase == 2)) begin errors++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush, m_phase == 2); end
      checks++; if (new_pc !== m_pc) begin errors++; $display("FAIL rnd_new_pc cyc=%0d got=%h exp=%h", i, new_pc, m_pc); end
      checks++; if (wdog_err !== m_err) begin errors++; $display("FAIL rnd_wdog cyc=%0d got=%b exp=%b", i, wdog_err, m_err); end
      checks++; if (stall_cycles !== m_cyc) begin errors++; $display("FAIL rnd_cycles cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_cyc); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exception();
    test_eret();
    test_excp_during_stall();
    test_watchdog();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
